// File: rtl/powerup_effect_manager_if.sv
// Power-up capsule interface: catch strobe and effect selects in, effect state out.
// master = power-up generator / game side, slave = powerup_effect_manager.
interface powerup_effect_manager_if;
  logic       PowOn;
  logic       PaddleSizeUpPow;
  logic       PaddleSizeDownPow;
  logic       ballSizeUp;
  logic       ballSizeDown;
  logic       wrapAround;
  logic       lifeUp;
  logic       levelChange;
  logic       noMore;
  logic       ballLost;
  logic [9:0] paddleSize;
  logic [9:0] ballSize;
  logic       wrapEn;
  logic [3:0] lives;
  logic       gameOver;
  logic       powAck;
  logic       effectActive;
  logic [9:0] effectTimer;
  logic       expiring;

  modport master (
    output PowOn, PaddleSizeUpPow, PaddleSizeDownPow, ballSizeUp, ballSizeDown,
           wrapAround, lifeUp, levelChange, noMore, ballLost,
    input  paddleSize, ballSize, wrapEn, lives, gameOver, powAck,
           effectActive, effectTimer, expiring
  );

  modport slave (
    input  PowOn, PaddleSizeUpPow, PaddleSizeDownPow, ballSizeUp, ballSizeDown,
           wrapAround, lifeUp, levelChange, noMore, ballLost,
    output paddleSize, ballSize, wrapEn, lives, gameOver, powAck,
           effectActive, effectTimer, expiring
  );
endinterface

// File: rtl/powerup_effect_manager.sv
// powerup_effect_manager: applies caught power-up effects to paddle width, ball
// radius, wrap-around and lives for a timed duration, restoring base values on expiry.
// Optional feature macro: POWERUP_WARN_EN (expiry-warning output; WARN_FRAMES only
// exists when it is defined).
module powerup_effect_manager #(
  parameter int PADDLE_BASE  = 80,
  parameter int PADDLE_BIG   = 120,
  parameter int PADDLE_SMALL = 40,
  parameter int BALL_BASE    = 4,
  parameter int BALL_BIG     = 8,
  parameter int BALL_SMALL   = 2,
  parameter int DURATION     = 600,
  parameter int LIVES_INIT   = 3,
`ifdef POWERUP_WARN_EN
  parameter int LIVES_MAX    = 9,
  parameter int WARN_FRAMES  = 120
`else
  parameter int LIVES_MAX    = 9
`endif
) (
  input  logic                     frame_clk,
  input  logic                     Reset_n,
  powerup_effect_manager_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, APPLY, ACTIVE} state_t;
  typedef enum logic [2:0] {K_NONE, K_LIFE, K_PUP, K_PDN, K_BUP, K_BDN, K_WRAP} kind_t;

  state_t     state, state_n;
  kind_t      kind, kind_n, sel_kind;
  logic       pow_on_d;
  logic       catch_ev;
  logic [9:0] paddle_q, paddle_n;
  logic [9:0] ball_q, ball_n;
  logic       wrap_q, wrap_n;
  logic [3:0] lives_q, lives_n;
  logic [3:0] lives_inc, lives_dec;
  logic       ack_q, ack_n;
  logic [9:0] timer_q, timer_n;
  logic       apply_life;

  assign catch_ev   = bus.PowOn & ~pow_on_d;
  assign lives_inc  = (lives_q >= 4'(LIVES_MAX)) ? 4'(LIVES_MAX) : lives_q + 4'd1;
  assign lives_dec  = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
  assign apply_life = (state == APPLY) && (kind == K_LIFE);

  // Effect-select priority encoder: first flag set wins.
  always_comb begin
    sel_kind = K_NONE;
    if      (bus.lifeUp)            sel_kind = K_LIFE;
    else if (bus.PaddleSizeUpPow)   sel_kind = K_PUP;
    else if (bus.PaddleSizeDownPow) sel_kind = K_PDN;
    else if (bus.ballSizeUp)        sel_kind = K_BUP;
    else if (bus.ballSizeDown)      sel_kind = K_BDN;
    else if (bus.wrapAround)        sel_kind = K_WRAP;
  end

  // Next-state and next-output logic: clears, then ball loss, then normal sequencing.
  always_comb begin
    state_n  = state;
    kind_n   = kind;
    paddle_n = paddle_q;
    ball_n   = ball_q;
    wrap_n   = wrap_q;
    lives_n  = lives_q;
    timer_n  = timer_q;
    ack_n    = 1'b0;

    if (bus.noMore || bus.levelChange) begin
      paddle_n = 10'(PADDLE_BASE);
      ball_n   = 10'(BALL_BASE);
      wrap_n   = 1'b0;
      timer_n  = '0;
      state_n  = IDLE;
      kind_n   = K_NONE;
      if (bus.noMore)        lives_n = 4'(LIVES_INIT);
      else if (bus.ballLost) lives_n = lives_dec;
    end else if (bus.ballLost) begin
      paddle_n = 10'(PADDLE_BASE);
      ball_n   = 10'(BALL_BASE);
      wrap_n   = 1'b0;
      timer_n  = '0;
      // A lifeUp landing on the same edge cancels the loss.
      lives_n  = apply_life ? lives_q : lives_dec;
      if (catch_ev) begin
        state_n = APPLY;
        kind_n  = sel_kind;
        ack_n   = 1'b1;
      end else begin
        state_n = IDLE;
        kind_n  = K_NONE;
      end
    end else begin
      // The timer keeps running through a lifeUp catch/APPLY so that an ongoing
      // effect is left untouched; expiry restores base values wherever it lands.
      if (timer_q != '0) begin
        timer_n = timer_q - 10'd1;
        if (timer_q == 10'd1) begin
          paddle_n = 10'(PADDLE_BASE);
          ball_n   = 10'(BALL_BASE);
          wrap_n   = 1'b0;
        end
      end

      unique case (state)
        IDLE: ;
        ACTIVE: begin
          if (timer_q == 10'd1) state_n = IDLE;
        end
        APPLY: begin
          if (kind == K_LIFE || kind == K_NONE) begin
            if (kind == K_LIFE) lives_n = lives_inc;
            state_n = (timer_q > 10'd1) ? ACTIVE : IDLE;
          end else begin
            paddle_n = 10'(PADDLE_BASE);
            ball_n   = 10'(BALL_BASE);
            wrap_n   = 1'b0;
            unique case (kind)
              K_PUP:   paddle_n = 10'(PADDLE_BIG);
              K_PDN:   paddle_n = 10'(PADDLE_SMALL);
              K_BUP:   ball_n   = 10'(BALL_BIG);
              K_BDN:   ball_n   = 10'(BALL_SMALL);
              default: wrap_n   = 1'b1;
            endcase
            timer_n = 10'(DURATION);
            state_n = ACTIVE;
          end
          kind_n = K_NONE;
        end
        default: state_n = IDLE;
      endcase

      if (catch_ev) begin
        state_n = APPLY;
        kind_n  = sel_kind;
        ack_n   = 1'b1;
      end
    end
  end

  // FSM state and latched kind register.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      kind  <= K_NONE;
    end else begin
      state <= state_n;
      kind  <= kind_n;
    end
  end

  // Effect output, lives, timer and catch-edge registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pow_on_d <= 1'b0;
      paddle_q <= 10'(PADDLE_BASE);
      ball_q   <= 10'(BALL_BASE);
      wrap_q   <= 1'b0;
      lives_q  <= 4'(LIVES_INIT);
      ack_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      pow_on_d <= bus.PowOn;
      paddle_q <= paddle_n;
      ball_q   <= ball_n;
      wrap_q   <= wrap_n;
      lives_q  <= lives_n;
      ack_q    <= ack_n;
      timer_q  <= timer_n;
    end
  end

  assign bus.paddleSize   = paddle_q;
  assign bus.ballSize     = ball_q;
  assign bus.wrapEn       = wrap_q;
  assign bus.lives        = lives_q;
  assign bus.gameOver     = (lives_q == 4'd0);
  assign bus.powAck       = ack_q;
  assign bus.effectActive = (state == ACTIVE);
  assign bus.effectTimer  = timer_q;

`ifdef POWERUP_WARN_EN
  assign bus.expiring = (state == ACTIVE) && (timer_q <= 10'(WARN_FRAMES));
`else
  assign bus.expiring = 1'b0;
`endif

endmodule

// File: tb/tb_powerup_effect_manager.sv
// Testbench for powerup_effect_manager: directed scenarios followed by random
// frames, all checked against a frame-level reference model of the game rules.
module tb_powerup_effect_manager;

  localparam int DUR  = 600;
  localparam int WARN = 120;

  logic frame_clk;
  logic Reset_n;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  powerup_effect_manager_if bus();

  powerup_effect_manager dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus.slave)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Reference model. Effect codes: 0 none, 1 paddle up, 2 paddle down,
  // 3 ball up, 4 ball down, 5 wrap, 6 life. pend = -1 means no catch waiting.
  int m_eff, m_rem, m_pend, m_lives;
  bit m_prev, m_ack;

  function automatic int sel_code();
    if (bus.lifeUp)            return 6;
    if (bus.PaddleSizeUpPow)   return 1;
    if (bus.PaddleSizeDownPow) return 2;
    if (bus.ballSizeUp)        return 3;
    if (bus.ballSizeDown)      return 4;
    if (bus.wrapAround)        return 5;
    return 0;
  endfunction

  task automatic model_reset();
    m_eff = 0; m_rem = 0; m_pend = -1; m_lives = 3; m_prev = 0; m_ack = 0;
  endtask

  task automatic model_edge();
    bit catch_ev;
    catch_ev = bus.PowOn && !m_prev;
    m_prev   = bus.PowOn;
    m_ack    = 0;
    if (bus.noMore || bus.levelChange) begin
      m_eff = 0; m_rem = 0; m_pend = -1;
      if (bus.noMore) m_lives = 3;
      else if (bus.ballLost) m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    end else if (bus.ballLost) begin
      if (m_pend != 6) m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      m_eff = 0; m_rem = 0;
      m_pend = catch_ev ? sel_code() : -1;
      m_ack  = catch_ev;
    end else begin
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_eff = 0;
      end
      if (m_pend == 6) m_lives = (m_lives < 9) ? m_lives + 1 : 9;
      else if (m_pend >= 1) begin m_eff = m_pend; m_rem = DUR; end
      m_pend = -1;
      if (catch_ev) begin m_pend = sel_code(); m_ack = 1; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    bit act;
    act = (m_rem > 0) && (m_pend == -1);
    chk("paddleSize", bus.paddleSize, (m_eff == 1) ? 120 : (m_eff == 2) ? 40 : 80);
    chk("ballSize", bus.ballSize, (m_eff == 3) ? 8 : (m_eff == 4) ? 2 : 4);
    chk("wrapEn", bus.wrapEn, (m_eff == 5) ? 1 : 0);
    chk("lives", bus.lives, m_lives);
    chk("gameOver", bus.gameOver, (m_lives == 0) ? 1 : 0);
    chk("powAck", bus.powAck, m_ack);
    chk("effectActive", bus.effectActive, act);
    chk("effectTimer", bus.effectTimer, m_rem);
`ifdef POWERUP_WARN_EN
    chk("expiring", bus.expiring, (act && m_rem <= WARN) ? 1 : 0);
`else
    chk("expiring", bus.expiring, 0);
`endif
  endtask

  task automatic step();
    @(posedge frame_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_flags();
    bus.PaddleSizeUpPow = 0; bus.PaddleSizeDownPow = 0; bus.ballSizeUp = 0;
    bus.ballSizeDown = 0; bus.wrapAround = 0; bus.lifeUp = 0;
  endtask

  // One catch: PowOn high for one frame then low.
  task automatic catch_pulse();
    bus.PowOn = 1; step();
    bus.PowOn = 0; step();
  endtask

  initial begin
    int cnt;
    int acks;
    Reset_n = 0;
    bus.PowOn = 0; bus.levelChange = 0; bus.noMore = 0; bus.ballLost = 0;
    clear_flags();
    model_reset();
    #12;
    check_all();
    Reset_n = 1;
    step(); step();

    // Paddle size-up: one ack, exactly DUR frames at 120, then base.
    bus.PaddleSizeUpPow = 1;
    bus.PowOn = 1; step();
    chk("ack_on_catch", bus.powAck, 1);
    bus.PowOn = 0; step();
    clear_flags();
    cnt = 0;
    while (bus.paddleSize == 10'd120 && cnt < 700) begin cnt++; step(); end
    chk("paddle_up_frames", cnt, DUR);
    chk("paddle_restored", bus.paddleSize, 80);
    chk("inactive_after", bus.effectActive, 0);

    // PowOn held high: single catch, timer keeps running.
    bus.ballSizeUp = 1; bus.PowOn = 1;
    acks = 0;
    for (int i = 0; i < 50; i++) begin step(); if (bus.powAck) acks++; end
    chk("held_single_ack", acks, 1);
    chk("held_ball_big", bus.ballSize, 8);
    chk("held_timer", bus.effectTimer, DUR - 48);
    bus.PowOn = 0; clear_flags();

    // Replace ball-up at timer 300 with paddle-down.
    cnt = 0;
    while (bus.effectTimer != 10'd300 && cnt < 400) begin cnt++; step(); end
    chk("reach_300", bus.effectTimer, 300);
    bus.PaddleSizeDownPow = 1;
    catch_pulse();
    clear_flags();
    chk("replace_ball", bus.ballSize, 4);
    chk("replace_paddle", bus.paddleSize, 40);
    chk("replace_timer", bus.effectTimer, DUR);

    // Lives saturation, loss to zero, and loss cancelled by lifeUp APPLY.
    bus.lifeUp = 1;
    for (int i = 0; i < 8; i++) catch_pulse();
    chk("lives_sat", bus.lives, 9);
    bus.lifeUp = 0;
    for (int i = 0; i < 8; i++) begin bus.ballLost = 1; step(); bus.ballLost = 0; step(); end
    chk("lives_one", bus.lives, 1);
    bus.ballLost = 1; step(); bus.ballLost = 0;
    chk("lives_zero", bus.lives, 0);
    chk("game_over", bus.gameOver, 1);
    bus.ballLost = 1; step(); bus.ballLost = 0;
    chk("lives_floor", bus.lives, 0);
    bus.lifeUp = 1;
    catch_pulse(); catch_pulse();
    chk("lives_two", bus.lives, 2);
    bus.PowOn = 1; step();
    bus.PowOn = 0; bus.ballLost = 1; step();
    bus.ballLost = 0; clear_flags();
    chk("loss_vs_life", bus.lives, 2);

    // levelChange on the wrap APPLY edge suppresses the effect.
    bus.wrapAround = 1;
    bus.PowOn = 1; step();
    bus.PowOn = 0; bus.levelChange = 1; step();
    bus.levelChange = 0; clear_flags();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin step(); if (bus.wrapEn) cnt++; end
    chk("wrap_suppressed", cnt, 0);

`ifdef POWERUP_WARN_EN
    bus.wrapAround = 1;
    catch_pulse();
    clear_flags();
    cnt = 0;
    while (bus.effectTimer != 10'd121 && cnt < 700) begin cnt++; step(); end
    chk("warn_before", bus.expiring, 0);
    step();
    chk("warn_timer", bus.effectTimer, WARN);
    chk("warn_rise", bus.expiring, 1);
`endif

    // Asynchronous reset in the middle of an effect.
    bus.ballSizeDown = 1;
    catch_pulse();
    clear_flags();
    step(); step();
    #2 Reset_n = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_timer", bus.effectTimer, 0);
    chk("rst_lives", bus.lives, 3);
    Reset_n = 1;
    step();

    // Random frames.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) bus.PowOn = ~bus.PowOn;
      bus.PaddleSizeUpPow   = $urandom_range(0, 3) == 0;
      bus.PaddleSizeDownPow = $urandom_range(0, 3) == 0;
      bus.ballSizeUp        = $urandom_range(0, 3) == 0;
      bus.ballSizeDown      = $urandom_range(0, 3) == 0;
      bus.wrapAround        = $urandom_range(0, 3) == 0;
      bus.lifeUp            = $urandom_range(0, 5) == 0;
      bus.ballLost          = $urandom_range(0, 79) == 0;
      bus.levelChange       = $urandom_range(0, 299) == 0;
      bus.noMore            = $urandom_range(0, 799) == 0;
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
